// File: rtl/spi_adxl362_pkg.sv
// Shared constants, state encoding and a small helper for the ADXL362-style SPI responder.
package spi_adxl362_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h0A;
    localparam logic [7:0] CMD_READ     = 8'h0B;
    localparam logic [7:0] REG_DEVID_AD = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR_W = 3'd2,
        ST_ADDR_R = 3'd3,
        ST_DATA_W = 3'd4,
        ST_DATA_R = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    // Completes a byte from the 7 bits already held plus the bit arriving now.
    function automatic logic [7:0] shiftIn(input logic [6:0] held, input logic newBit);
        return {held, newBit};
    endfunction

endpackage

// File: rtl/spi_adxl362_responder_sync_edge.sv
// Multi-flop synchronizer for an asynchronous line plus registered rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clkIn,
    input  logic rstIn,
    input  logic asyncIn,
    output logic riseOut,
    output logic fallOut
);

    logic [STAGES-1:0] chain;
    logic              prevQ;

    // Pulses are registered so a line change shows up as an edge STAGES+1 cycles later.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            chain   <= '0;
            prevQ   <= 1'b0;
            riseOut <= 1'b0;
            fallOut <= 1'b0;
        end else begin
            chain   <= {chain[STAGES-2:0], asyncIn};
            prevQ   <= chain[STAGES-1];
            riseOut <= chain[STAGES-1] & ~prevQ;
            fallOut <= ~chain[STAGES-1] & prevQ;
        end
    end

endmodule

// File: rtl/spi_adxl362_responder.sv
// SPI mode-0 register-access responder modelled on the ADXL362 command set,
// fully oversampled on clkIn (SCLK never clocks any flop).
module spi_adxl362_responder
    import spi_adxl362_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 6,
    parameter int         RO_LIMIT    = 4,
    parameter logic [7:0] DEVID       = 8'hAD,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  sclkIn,
    input  logic                  csLowIn,
    input  logic                  mosiIn,
    output logic                  misoOut,
    output logic                  misoOeOut,
    output logic                  wrStrobeOut,
    output logic [ADDR_WIDTH-1:0] wrAddrOut,
    output logic [7:0]            wrDataOut,
    output logic                  rdStrobeOut,
    output logic                  xferActiveOut,
    output logic                  errCmdOut,
    output logic [2:0]            dbgState
);

    localparam int                  DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] RO_LIM = RO_LIMIT[ADDR_WIDTH:0];

    state_t                  state;
    logic [2:0]              bitCnt;
    logic [6:0]              rxShift;
    logic [7:0]              txShift;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [7:0]              regs [DEPTH];

    logic [SYNC_STAGES-1:0]  csChain;
    logic [SYNC_STAGES-1:0]  mosiChain;
    logic                    csSync;
    logic                    mosiSync;
    logic                    sclkRise;
    logic                    sclkFall;
    logic [7:0]              rxByte;
    logic                    byteDone;
    logic [ADDR_WIDTH-1:0]   rxAddr;
    logic [ADDR_WIDTH-1:0]   addrInc;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) sclkSync (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .asyncIn (sclkIn),
        .riseOut (sclkRise),
        .fallOut (sclkFall)
    );

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            csChain   <= '1;
            mosiChain <= '0;
        end else begin
            csChain   <= {csChain[SYNC_STAGES-2:0], csLowIn};
            mosiChain <= {mosiChain[SYNC_STAGES-2:0], mosiIn};
        end
    end

    assign csSync   = csChain[SYNC_STAGES-1];
    assign mosiSync = mosiChain[SYNC_STAGES-1];
    assign rxByte   = shiftIn(rxShift, mosiSync);
    assign byteDone = sclkRise && (bitCnt == 3'd7);
    assign rxAddr   = rxByte[ADDR_WIDTH-1:0];
    assign addrInc  = addr + 1'b1;

    // wrStrobeOut/rdStrobeOut/errCmdOut are single-cycle valid pulses with no
    // ready/backpressure: a consumer must capture them (and wrAddrOut/wrDataOut)
    // in the cycle they are high.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state       <= ST_IDLE;
            bitCnt      <= 3'd0;
            rxShift     <= 7'd0;
            txShift     <= 8'd0;
            addr        <= '0;
            wrStrobeOut <= 1'b0;
            wrAddrOut   <= '0;
            wrDataOut   <= 8'd0;
            rdStrobeOut <= 1'b0;
            errCmdOut   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
            regs[REG_DEVID_AD[ADDR_WIDTH-1:0]] <= DEVID;
        end else begin
            wrStrobeOut <= 1'b0;
            rdStrobeOut <= 1'b0;
            errCmdOut   <= 1'b0;
            if (csSync) begin
                state  <= ST_IDLE;
                bitCnt <= 3'd0;
            end else if (state == ST_IDLE) begin
                state  <= ST_CMD;
                bitCnt <= 3'd0;
            end else begin
                // Only shift mid-byte: the falling edge that closes a byte must
                // not disturb the byte just loaded for the next transfer.
                if (sclkFall && (state == ST_DATA_R) && (bitCnt != 3'd0)) begin
                    txShift <= {txShift[6:0], 1'b0};
                end
                if (sclkRise) begin
                    rxShift <= rxByte[6:0];
                    bitCnt  <= bitCnt + 3'd1;
                end
                if (byteDone) begin
                    unique case (state)
                        ST_CMD: begin
                            if (rxByte == CMD_WRITE) begin
                                state <= ST_ADDR_W;
                            end else if (rxByte == CMD_READ) begin
                                state <= ST_ADDR_R;
                            end else begin
                                state     <= ST_IGNORE;
                                errCmdOut <= 1'b1;
                            end
                        end
                        ST_ADDR_W: begin
                            addr  <= rxAddr;
                            state <= ST_DATA_W;
                        end
                        ST_ADDR_R: begin
                            addr        <= rxAddr;
                            txShift     <= regs[rxAddr];
                            rdStrobeOut <= 1'b1;
                            state       <= ST_DATA_R;
                        end
                        ST_DATA_W: begin
                            if ({1'b0, addr} >= RO_LIM) begin
                                regs[addr]  <= rxByte;
                                wrStrobeOut <= 1'b1;
                                wrAddrOut   <= addr;
                                wrDataOut   <= rxByte;
                            end
                            addr <= addrInc;
                        end
                        ST_DATA_R: begin
                            addr        <= addrInc;
                            txShift     <= regs[addrInc];
                            rdStrobeOut <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign misoOeOut     = (state == ST_DATA_R) && !csSync;
    assign misoOut       = misoOeOut & txShift[7];
    assign xferActiveOut = ~csSync;
    assign dbgState      = state;

endmodule
